fetch_ctrl: RTL and testbench

- F-stage owner of the PC register, sitting between the next-PC unit, the hazard unit, CP0 and the instruction bus.
- Sequences instruction fetch over a single-outstanding req/ready bus and holds the fetched word while D stalls.
- Arbitrates the PC source: redirect (exception entry / eret target from CP0) over stall over sequential next-PC.
- Detects fetch address errors (AdEL) and reports them instead of issuing a bus request.

---
 rtl/fetch_ctrl_pkg.sv | 17 +
 rtl/fetch_addr_check.sv | 12 +
 rtl/fetch_ctrl.sv | 101 ++++++++++
 tb/tb_fetch_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and address constants for the F-stage fetch controller.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        FC_START = 2'd0,
        FC_REQ   = 2'd1,
        FC_HOLD  = 2'd2,
        FC_KILL  = 2'd3
    } fc_state_t;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] DEF_TEXT_BASE  = 32'h0000_3000;
    localparam logic [31:0] DEF_TEXT_LIMIT = 32'h0000_6FFC;
    // Exception handler entry used by CP0 as a redirect target.
    localparam logic [31:0] HANDLE_PC      = 32'h0000_4180;

endpackage

// File: rtl/fetch_addr_check.sv
// Combinational fetch address check: misaligned or outside the text window.
module fetch_addr_check #(
    parameter logic [31:0] TEXT_BASE  = 32'h0000_3000,
    parameter logic [31:0] TEXT_LIMIT = 32'h0000_6FFC
) (
    input  logic [31:0] pc,
    output logic        bad
);

    assign bad = (pc[1:0] != 2'b00) || (pc < TEXT_BASE) || (pc > TEXT_LIMIT);

endmodule

// File: rtl/fetch_ctrl.sv
// F-stage PC owner: single-outstanding instruction fetch, redirect/stall arbitration, AdEL detection.
//
// state | meaning
// START | first cycle after reset, no request yet
// REQ   | request pc on the bus (or report AdEL if pc is bad)
// HOLD  | fetched word / AdEL presented to D until it advances
// KILL  | redirected with a request in flight; wait out the response and drop it
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] TEXT_BASE  = DEF_TEXT_BASE,
    parameter logic [31:0] TEXT_LIMIT = DEF_TEXT_LIMIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] seq_npc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic [31:0] F_pc,
    output logic        F_valid,
    output logic [31:0] F_instr,
    output logic        F_excAdEL,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_ready,
    input  logic [31:0] ibus_rdata
);

    fc_state_t   state;
    logic [31:0] pc;
    logic [31:0] kill_addr;
    logic        pc_bad;

    fetch_addr_check #(
        .TEXT_BASE (TEXT_BASE),
        .TEXT_LIMIT(TEXT_LIMIT)
    ) u_addr_check (
        .pc (pc),
        .bad(pc_bad)
    );

    assign F_pc      = pc;
    // A request to a bad address is never issued; a killed request stays up until answered.
    assign ibus_req  = ((state == FC_REQ) && !pc_bad) || (state == FC_KILL);
    assign ibus_addr = (state == FC_KILL) ? kill_addr : pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FC_START;
            pc        <= RESET_PC;
            kill_addr <= 32'h0;
            F_valid   <= 1'b0;
            F_instr   <= 32'h0;
            F_excAdEL <= 1'b0;
        end else begin
            case (state)
                FC_START: begin
                    if (redirect) pc <= redirect_pc;
                    state <= FC_REQ;
                end
                FC_REQ: begin
                    if (redirect && ibus_ready) begin
                        pc <= redirect_pc;
                    end else if (redirect && !pc_bad) begin
                        kill_addr <= pc;
                        pc        <= redirect_pc;
                        state     <= FC_KILL;
                    end else if (redirect) begin
                        pc <= redirect_pc;
                    end else if (pc_bad) begin
                        F_valid   <= 1'b1;
                        F_excAdEL <= 1'b1;
                        F_instr   <= 32'h0;
                        state     <= FC_HOLD;
                    end else if (ibus_ready) begin
                        F_valid <= 1'b1;
                        F_instr <= ibus_rdata;
                        state   <= FC_HOLD;
                    end
                end
                FC_HOLD: begin
                    if (redirect || !stall) begin
                        pc        <= redirect ? redirect_pc : seq_npc;
                        F_valid   <= 1'b0;
                        F_excAdEL <= 1'b0;
                        F_instr   <= 32'h0;
                        state     <= FC_REQ;
                    end
                end
                FC_KILL: begin
                    if (redirect) pc <= redirect_pc;
                    if (ibus_ready) state <= FC_REQ;
                end
                default: state <= FC_START;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, hand sequences, and random traffic against a reference model.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] seq_npc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [31:0] F_pc;
    logic        F_valid;
    logic [31:0] F_instr;
    logic        F_excAdEL;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_ready;
    logic [31:0] ibus_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .seq_npc    (seq_npc),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .stall      (stall),
        .F_pc       (F_pc),
        .F_valid    (F_valid),
        .F_instr    (F_instr),
        .F_excAdEL  (F_excAdEL),
        .ibus_req   (ibus_req),
        .ibus_addr  (ibus_addr),
        .ibus_ready (ibus_ready),
        .ibus_rdata (ibus_rdata)
    );

    typedef struct {
        bit          rs;
        bit          r;
        logic [31:0] rpc;
        bit          st;
        logic [31:0] npc;
        bit          rdy;
        logic [31:0] rd;
        bit          ev;
        logic [31:0] ei;
        bit          ee;
        logic [31:0] ep;
        bit          eq;
        logic [31:0] ea;
    } vec_t;

    vec_t tbl[$];

    // Reference model: what has the stage got, and is a dead request being waited out.
    bit          m_started;
    bit          m_killing;
    logic [31:0] m_kill_addr;
    logic [31:0] m_pc;
    bit          m_valid;
    logic [31:0] m_instr;
    bit          m_exc;

    function automatic bit m_bad(logic [31:0] a);
        return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
    endfunction

    function automatic bit m_req();
        return m_killing || (m_started && !m_valid && !m_bad(m_pc));
    endfunction

    task automatic model_step();
        bit b;
        if (reset) begin
            m_started = 0; m_killing = 0; m_kill_addr = 0;
            m_pc = 32'h3000; m_valid = 0; m_instr = 0; m_exc = 0;
        end else if (!m_started) begin
            if (redirect) m_pc = redirect_pc;
            m_started = 1;
        end else if (m_killing) begin
            if (redirect) m_pc = redirect_pc;
            if (ibus_ready) m_killing = 0;
        end else if (m_valid) begin
            if (redirect || !stall) begin
                m_pc = redirect ? redirect_pc : seq_npc;
                m_valid = 0; m_instr = 0; m_exc = 0;
            end
        end else begin
            b = m_bad(m_pc);
            if (redirect) begin
                if (!ibus_ready && !b) begin
                    m_killing = 1;
                    m_kill_addr = m_pc;
                end
                m_pc = redirect_pc;
            end else if (b) begin
                m_valid = 1; m_exc = 1; m_instr = 0;
            end else if (ibus_ready) begin
                m_valid = 1; m_instr = ibus_rdata;
            end
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(bit rs, bit r, logic [31:0] rpc, bit st, logic [31:0] npc,
                         bit rdy, logic [31:0] rd);
        reset = rs; redirect = r; redirect_pc = rpc; stall = st;
        seq_npc = npc; ibus_ready = rdy; ibus_rdata = rd;
        @(negedge clk);
    endtask

    task automatic clock_edge();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk_all(string tag, bit ev, logic [31:0] ei, bit ee, logic [31:0] ep,
                           bit eq, logic [31:0] ea);
        chk({tag, ".F_valid"}, {31'h0, F_valid}, {31'h0, ev});
        chk({tag, ".F_instr"}, F_instr, ei);
        chk({tag, ".F_excAdEL"}, {31'h0, F_excAdEL}, {31'h0, ee});
        chk({tag, ".F_pc"}, F_pc, ep);
        chk({tag, ".ibus_req"}, {31'h0, ibus_req}, {31'h0, eq});
        if (eq) chk({tag, ".ibus_addr"}, ibus_addr, ea);
    endtask

    task automatic add(bit r, logic [31:0] rpc, bit st, logic [31:0] npc, bit rdy, logic [31:0] rd,
                       bit ev, logic [31:0] ei, bit ee, logic [31:0] ep, bit eq, logic [31:0] ea);
        tbl.push_back('{1'b0, r, rpc, st, npc, rdy, rd, ev, ei, ee, ep, eq, ea});
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 3))
            0: return 32'h4180;
            1: return 32'h3000 + 32'(4 * $urandom_range(0, 32'hFFF));
            2: return $urandom();
            default: begin
                case ($urandom_range(0, 3))
                    0: return 32'h3000;
                    1: return 32'h6FFC;
                    2: return 32'h2FFC;
                    default: return 32'h7000;
                endcase
            end
        endcase
    endfunction

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);
        clock_edge();
        clock_edge();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk_all("reset", 0, 0, 0, 32'h3000, 0, 0);
        clock_edge();

        //   r  rpc       st npc       rdy rd            ev ei            ee ep        eq ea
        add(0, 0,        0, 0,        0, 0,            0, 0,            0, 32'h3000, 0, 0);
        add(0, 0,        0, 0,        0, 0,            0, 0,            0, 32'h3000, 1, 32'h3000);
        add(0, 0,        0, 0,        1, 32'h24080001, 0, 0,            0, 32'h3000, 1, 32'h3000);
        add(0, 0,        1, 32'h3004, 0, 0,            1, 32'h24080001, 0, 32'h3000, 0, 0);
        add(0, 0,        1, 32'h3004, 0, 0,            1, 32'h24080001, 0, 32'h3000, 0, 0);
        add(0, 0,        1, 32'h3004, 0, 0,            1, 32'h24080001, 0, 32'h3000, 0, 0);
        add(0, 0,        0, 32'h3004, 0, 0,            1, 32'h24080001, 0, 32'h3000, 0, 0);
        add(0, 0,        0, 0,        0, 0,            0, 0,            0, 32'h3004, 1, 32'h3004);
        add(0, 0,        0, 0,        1, 32'h3c010000, 0, 0,            0, 32'h3004, 1, 32'h3004);
        add(0, 0,        0, 32'h3008, 0, 0,            1, 32'h3c010000, 0, 32'h3004, 0, 0);
        add(1, 32'h4180, 0, 0,        0, 0,            0, 0,            0, 32'h3008, 1, 32'h3008);
        add(0, 0,        0, 0,        0, 0,            0, 0,            0, 32'h4180, 1, 32'h3008);
        add(0, 0,        0, 0,        1, 32'hdeadbeef, 0, 0,            0, 32'h4180, 1, 32'h3008);
        add(0, 0,        0, 0,        1, 32'h24090002, 0, 0,            0, 32'h4180, 1, 32'h4180);
        add(0, 0,        0, 32'h3002, 0, 0,            1, 32'h24090002, 0, 32'h4180, 0, 0);
        add(0, 0,        0, 0,        0, 0,            0, 0,            0, 32'h3002, 0, 0);
        add(0, 0,        1, 0,        0, 0,            1, 0,            1, 32'h3002, 0, 0);
        add(0, 0,        0, 32'h7000, 0, 0,            1, 0,            1, 32'h3002, 0, 0);
        add(0, 0,        0, 0,        0, 0,            0, 0,            0, 32'h7000, 0, 0);
        add(1, 32'h4180, 1, 0,        0, 0,            1, 0,            1, 32'h7000, 0, 0);
        add(1, 32'h5000, 0, 0,        1, 32'h11111111, 0, 0,            0, 32'h4180, 1, 32'h4180);
        add(0, 0,        0, 0,        1, 32'h22222222, 0, 0,            0, 32'h5000, 1, 32'h5000);
        add(1, 32'h4180, 1, 0,        0, 0,            1, 32'h22222222, 0, 32'h5000, 0, 0);
        add(0, 0,        0, 0,        1, 32'h33333333, 0, 0,            0, 32'h4180, 1, 32'h4180);
        add(0, 0,        0, 32'h6ffe, 0, 0,            1, 32'h33333333, 0, 32'h4180, 0, 0);
        add(1, 32'h6ffc, 0, 0,        0, 0,            0, 0,            0, 32'h6ffe, 0, 0);
        add(0, 0,        0, 0,        1, 32'h44444444, 0, 0,            0, 32'h6ffc, 1, 32'h6ffc);
        add(0, 0,        0, 32'h2ffc, 0, 0,            1, 32'h44444444, 0, 32'h6ffc, 0, 0);
        add(0, 0,        0, 0,        0, 0,            0, 0,            0, 32'h2ffc, 0, 0);
        add(0, 0,        1, 0,        0, 0,            1, 0,            1, 32'h2ffc, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].rs, tbl[i].r, tbl[i].rpc, tbl[i].st, tbl[i].npc, tbl[i].rdy, tbl[i].rd);
            chk_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ei, tbl[i].ee, tbl[i].ep,
                    tbl[i].eq, tbl[i].ea);
            clock_edge();
        end

        // Reset while a killed request is outstanding, then a redirect in START.
        drive(0, 0, 0, 0, 32'h3000, 0, 0);
        clock_edge();
        drive(0, 1, 32'h4180, 0, 0, 0, 0);
        chk_all("kill_pre", 0, 0, 0, 32'h3000, 1, 32'h3000);
        clock_edge();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk_all("kill_wait", 0, 0, 0, 32'h4180, 1, 32'h3000);
        clock_edge();
        drive(0, 1, 32'h5000, 0, 0, 0, 0);
        chk_all("kill_reset", 0, 0, 0, 32'h3000, 0, 0);
        clock_edge();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk_all("start_redirect", 0, 0, 0, 32'h5000, 1, 32'h5000);
        clock_edge();

        // Random traffic against the model; ready only answers an active request.
        drive(1, 0, 0, 0, 0, 0, 0);
        clock_edge();
        for (int n = 0; n < 4000; n++) begin
            bit          rs, r, st, rdy;
            logic [31:0] rpc, npc;
            rs  = ($urandom_range(0, 499) == 0);
            r   = ($urandom_range(0, 7) == 0);
            rpc = pick_addr();
            st  = ($urandom_range(0, 2) == 0);
            npc = ($urandom_range(0, 4) != 0) ? m_pc + 32'd4 : pick_addr();
            rdy = m_req() && ($urandom_range(0, 2) == 0);
            drive(rs, r, rpc, st, npc, rdy, $urandom());
            chk_all("rand", m_valid, m_instr, m_exc, m_pc, m_req(),
                    m_killing ? m_kill_addr : m_pc);
            clock_edge();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
